// File: rtl/counter_updown_mod.sv
// Up/down counter with a runtime modulus (0..max_val), wrap or saturate mode,
// synchronous clear/load, one-cycle boundary pulses and a sticky event flag.
module counter_updown_mod #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow,
  output logic             event_sticky
);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt, unf_nxt, sticky_nxt;
  logic             at_top, at_zero;

  // count >= max_val covers a modulus lowered below the live count.
  assign at_top  = (count >= max_val);
  assign at_zero = (count == '0);

  // Terminal count follows the current direction, not registered.
  assign tc = up_dn ? at_top : at_zero;

  // Next-state selection: clear > load > enable > hold.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > max_val) ? max_val : load_val;
    end else if (enable) begin
      if (up_dn) begin
        if (at_top) begin
          count_nxt = mode ? max_val : '0;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          count_nxt = mode ? '0 : max_val;
          unf_nxt   = 1'b1;
        end else if (count > max_val) begin
          // Modulus dropped under us: pull back into range without a pulse.
          count_nxt = max_val;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // A new event beats a same-cycle flag clear.
  always_comb begin
    sticky_nxt = event_sticky;
    if (ovf_nxt || unf_nxt) sticky_nxt = 1'b1;
    else if (clr_flags)     sticky_nxt = 1'b0;
  end

  // State and pulse registers, async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= RESET_VAL;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      event_sticky <= 1'b0;
    end else begin
      count        <= count_nxt;
      overflow     <= ovf_nxt;
      underflow    <= unf_nxt;
      event_sticky <= sticky_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: the driver pushes hand-computed expectations per edge,
// the monitor pops and compares after each rising edge.
module tb_counter_updown_mod;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, up_dn, mode, clear, load, clr_flags;
  logic [W-1:0] max_val, load_val;
  logic [W-1:0] count;
  logic         tc, overflow, underflow, event_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] cnt;
    logic         ovf, unf, stk, tc;
    string        nm;
  } exp_t;

  exp_t q[$];

  counter_updown_mod #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .mode(mode),
    .max_val(max_val), .clear(clear), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(count), .tc(tc), .overflow(overflow),
    .underflow(underflow), .event_sticky(event_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Drive one edge worth of inputs and queue what must appear after it.
  task automatic step(input logic en, input logic up, input logic md,
                      input logic [W-1:0] mx, input logic cl, input logic ld,
                      input logic [W-1:0] lv, input logic cf,
                      input logic [W-1:0] ec, input logic eo, input logic eu,
                      input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    enable = en; up_dn = up; mode = md; max_val = mx;
    clear = cl; load = ld; load_val = lv; clr_flags = cf;
    e.cnt = ec; e.ovf = eo; e.unf = eu; e.stk = es;
    e.tc  = up ? (ec >= mx) : (ec == '0);
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Monitor: every edge is an output presentation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.nm, ".count"},  8'(count),        8'(e.cnt));
        chk({e.nm, ".ovf"},    8'(overflow),     8'(e.ovf));
        chk({e.nm, ".unf"},    8'(underflow),    8'(e.unf));
        chk({e.nm, ".sticky"}, 8'(event_sticky), 8'(e.stk));
        chk({e.nm, ".tc"},     8'(tc),           8'(e.tc));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 0; up_dn = 1; mode = 0; max_val = 4'd15;
    clear = 0; load = 0; load_val = '0; clr_flags = 0;
    #20;
    chk("rst.count", 8'(count), 8'd0);
    chk("rst.ovf", 8'(overflow), 8'd0);
    chk("rst.unf", 8'(underflow), 8'd0);
    chk("rst.sticky", 8'(event_sticky), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full binary wrap at max 15
    for (int i = 1; i <= 15; i++)
      step(1,1,0,15, 0,0,0,0, W'(i),0,0,0, "full_up");
    step(1,1,0,15, 0,0,0,0, 0,1,0,1, "full_wrap");
    step(0,1,0,9, 0,0,0,1, 0,0,0,0, "clrflg0");

    // Modulus 9, wrap mode, up then down
    for (int i = 1; i <= 9; i++)
      step(1,1,0,9, 0,0,0,0, W'(i),0,0,0, "mod9_up");
    step(1,1,0,9, 0,0,0,0, 0,1,0,1, "mod9_wrap");
    step(1,1,0,9, 0,0,0,0, 1,0,0,1, "mod9_1");
    step(1,0,0,9, 0,0,0,0, 0,0,0,1, "dn_0");
    step(1,0,0,9, 0,0,0,0, 9,0,1,1, "dn_wrap");
    step(1,0,0,9, 0,0,0,0, 8,0,0,1, "dn_8");

    // Saturate mode
    step(0,1,1,5, 1,0,0,1, 0,0,0,0, "clr_cf");
    for (int i = 1; i <= 5; i++)
      step(1,1,1,5, 0,0,0,0, W'(i),0,0,0, "sat_up");
    for (int i = 0; i < 3; i++)
      step(1,1,1,5, 0,0,0,0, 5,1,0,1, "sat_hold");
    step(0,0,1,5, 1,0,0,0, 0,0,0,1, "clr");
    step(1,0,1,5, 0,0,0,0, 0,0,1,1, "sat_dn0a");
    step(1,0,1,5, 0,0,0,0, 0,0,1,1, "sat_dn0b");

    // Load / clear priority and modulus edge cases
    step(0,1,0,9, 0,1,12,0, 9,0,0,1, "ld_clamp");
    step(0,1,0,9, 1,1,5,0, 0,0,0,1, "clr_ld");
    step(1,1,0,9, 0,1,3,0, 3,0,0,1, "ld_en");
    step(1,1,0,2, 0,0,0,0, 0,1,0,1, "max_low_up");
    step(0,1,0,9, 0,1,8,0, 8,0,0,1, "ld8");
    step(1,0,0,4, 0,0,0,0, 4,0,0,1, "max_low_dn");
    step(1,1,0,0, 0,0,0,0, 0,1,0,1, "max0_up_a");
    step(1,1,0,0, 0,0,0,0, 0,1,0,1, "max0_up_b");
    step(1,0,0,0, 0,0,0,0, 0,0,1,1, "max0_dn");

    // Async reset mid-count
    step(0,1,0,15, 1,0,0,0, 0,0,0,1, "clr2");
    for (int i = 1; i <= 7; i++)
      step(1,1,0,15, 0,0,0,0, W'(i),0,0,1, "to7");
    drain();
    enable = 0;
    reset_n = 1'b0;
    #1;
    chk("midrst.count", 8'(count), 8'd0);
    chk("midrst.sticky", 8'(event_sticky), 8'd0);
    chk("midrst.pulse", 8'({overflow, underflow}), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1,1,0,15, 0,0,0,0, 1,0,0,0, "resume");

    // Sticky clear versus coincident event
    step(1,1,0,0, 0,0,0,0, 0,1,0,1, "stk_set");
    step(0,1,0,0, 0,0,0,1, 0,0,0,0, "stk_clr");
    step(1,1,0,0, 0,0,0,1, 0,1,0,1, "stk_win");
    step(0,1,0,0, 0,0,0,0, 0,0,0,1, "stk_hold");

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
